// File: rtl/periph_bus_arbiter_if.sv
// Two-master / one-slave peripheral bus bundle.
// master: arbiter side (drives the slave bus); slave: environment side.
interface periph_bus_arbiter_if;
  logic [1:0][31:0] m_awaddr;
  logic [1:0]       m_awvalid;
  logic [1:0]       m_awready;
  logic [1:0][31:0] m_wdata;
  logic [1:0]       m_wvalid;
  logic [1:0]       m_wready;
  logic [1:0]       m_bvalid;
  logic [1:0]       m_bready;
  logic [1:0][31:0] m_araddr;
  logic [1:0]       m_arvalid;
  logic [1:0]       m_arready;
  logic [1:0][31:0] m_rdata;
  logic [1:0]       m_rvalid;
  logic [1:0]       m_rready;

  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic        s_wvalid;
  logic        s_wready;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        s_rready;

  modport master (
    input  m_awaddr, m_awvalid, m_wdata, m_wvalid,
    input  m_bready, m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bvalid,
    output m_arready, m_rdata, m_rvalid,
    output s_awaddr, s_awvalid, s_wdata, s_wvalid,
    output s_bready, s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bvalid,
    input  s_arready, s_rdata, s_rvalid
  );

  modport slave (
    output m_awaddr, m_awvalid, m_wdata, m_wvalid,
    output m_bready, m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bvalid,
    input  m_arready, m_rdata, m_rvalid,
    input  s_awaddr, s_awvalid, s_wdata, s_wvalid,
    input  s_bready, s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bvalid,
    output s_arready, s_rdata, s_rvalid
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter of two masters onto one peripheral bus.
// Define PERIPH_BUS_ARBITER_TIMEOUT_EN for forced completion.
module periph_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int RR_INIT        = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  periph_bus_arbiter_if.master        bus,
  output logic [1:0]                  grant,
  output logic                        timeout
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA
  } state_t;

  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
  localparam logic        RR_LAST = (RR_INIT % 2) == 0;

  state_t      state;
  state_t      state_nxt;
  logic        g;
  logic        last;
  logic        win;
  logic        win_wr;
  logic        any_req;
  logic        done;
  logic        forced;
  logic        aw_pend;
  logic        w_pend;
  logic [1:0]  wr_req;
  logic [1:0]  req;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  assign wr_req  = bus.m_awvalid & bus.m_wvalid;
  assign req     = wr_req | bus.m_arvalid;
  assign any_req = |req;
  assign win     = (req == 2'b11) ? ~last : req[1];
  assign win_wr  = wr_req[win];
  assign done    = (state != IDLE) && (state_nxt == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) state_nxt = win_wr ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: begin
        if (forced) begin
          if (bus.m_bready[g]) state_nxt = IDLE;
        end else if ((!aw_pend || bus.s_awready) &&
                     (!w_pend || bus.s_wready)) begin
          state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.m_bready[g] && (forced || bus.s_bvalid))
          state_nxt = IDLE;
      end
      RD_ADDR: begin
        if (forced) begin
          if (bus.m_rready[g]) state_nxt = IDLE;
        end else if (bus.s_arready) begin
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.m_rready[g] && (forced || bus.s_rvalid))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request on its grant cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      g       <= 1'b0;
      last    <= RR_LAST;
      addr_q  <= '0;
      data_q  <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        g       <= win;
        addr_q  <= win_wr ? bus.m_awaddr[win]
                          : bus.m_araddr[win];
        data_q  <= win_wr ? bus.m_wdata[win] : '0;
        aw_pend <= win_wr;
        w_pend  <= win_wr;
      end
      if (state == WR_ADDR) begin
        if (bus.s_awready) aw_pend <= 1'b0;
        if (bus.s_wready)  w_pend  <= 1'b0;
      end
      if (done) last <= g;
    end
  end

`ifdef PERIPH_BUS_ARBITER_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || done) begin
      to_cnt <= '0;
      forced <= 1'b0;
    end else if (!forced) begin
      to_cnt <= to_cnt + 16'd1;
      forced <= to_cnt == 16'(TIMEOUT_CYCLES - 1);
    end
  end
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    bus.m_awready = '0;
    bus.m_wready  = '0;
    bus.m_arready = '0;
    bus.m_bvalid  = '0;
    bus.m_rvalid  = '0;
    bus.m_rdata   = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
    bus.s_awaddr  = addr_q;
    bus.s_araddr  = addr_q;
    bus.s_wdata   = data_q;
    grant         = '0;
    timeout       = forced && done;
    if (state != IDLE) grant[g] = 1'b1;
    unique case (state)
      IDLE: begin
        if (any_req && win_wr) begin
          bus.m_awready[win] = 1'b1;
          bus.m_wready[win]  = 1'b1;
        end else if (any_req) begin
          bus.m_arready[win] = 1'b1;
        end
      end
      WR_ADDR, WR_RESP: begin
        if (forced) begin
          bus.m_bvalid[g] = 1'b1;
        end else if (state == WR_ADDR) begin
          bus.s_awvalid = aw_pend;
          bus.s_wvalid  = w_pend;
        end else begin
          bus.s_bready    = bus.m_bready[g];
          bus.m_bvalid[g] = bus.s_bvalid;
        end
      end
      RD_ADDR, RD_DATA: begin
        if (forced) begin
          bus.m_rvalid[g] = 1'b1;
          bus.m_rdata[g]  = TO_DATA;
        end else if (state == RD_ADDR) begin
          bus.s_arvalid = 1'b1;
        end else begin
          bus.m_rvalid[g] = bus.s_rvalid;
          bus.m_rdata[g]  = bus.s_rdata;
          bus.s_rready    = bus.m_rready[g];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: slave-bus and master-response
// events are queued at issue and popped by a negedge monitor.
module tb_periph_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       timeout;

  always #5 clk = ~clk;

  periph_bus_arbiter_if bus ();

  periph_bus_arbiter #(
    .TIMEOUT_CYCLES(8),
    .RR_INIT(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant(grant),
    .timeout(timeout)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } sev_t;

  typedef struct packed {
    logic        is_r;
    logic        m;
    logic        to;
    logic [31:0] data;
  } rev_t;

  sev_t sq[$];
  rev_t rq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int awv_n = 0;
  int wv_n = 0;
  int ar_n[2];
  int aw_cyc[2];
  int ar_cyc[2];
  int b_cyc[2];
  int r_cyc[2];

  logic        hold_b;
  logic        hold_r;
  logic        w_stall;
  logic        w_seen;
  logic        got_aw;
  logic        got_w;
  logic        ar_pend;
  logic        aw_hs;
  logic        w_hs;
  logic [31:0] rd_addr;

  function automatic logic [31:0] rmodel(logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  function automatic sev_t sev(logic [1:0] k, logic [31:0] v);
    sev_t e;
    e.kind = k;
    e.val  = v;
    return e;
  endfunction

  function automatic rev_t rev(logic r, logic m, logic to,
                               logic [31:0] d);
    rev_t e;
    e.is_r = r;
    e.m    = m;
    e.to   = to;
    e.data = d;
    return e;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Zero-wait peripheral model with optional stalls
  assign bus.s_awready = 1'b1;
  assign bus.s_arready = 1'b1;
  assign bus.s_wready  = !(w_stall && !w_seen);
  assign aw_hs = bus.s_awvalid && bus.s_awready;
  assign w_hs  = bus.s_wvalid && bus.s_wready;

  always @(posedge clk) begin
    if (rst) begin
      got_aw       <= 1'b0;
      got_w        <= 1'b0;
      w_seen       <= 1'b0;
      ar_pend      <= 1'b0;
      rd_addr      <= '0;
      bus.s_bvalid <= 1'b0;
      bus.s_rvalid <= 1'b0;
      bus.s_rdata  <= '0;
    end else begin
      w_seen <= w_stall && (w_seen || bus.s_wvalid);
      if (bus.s_bvalid && bus.s_bready) bus.s_bvalid <= 1'b0;
      if ((got_aw || aw_hs) && (got_w || w_hs) && !hold_b) begin
        bus.s_bvalid <= 1'b1;
        got_aw       <= 1'b0;
        got_w        <= 1'b0;
      end else begin
        got_aw <= got_aw || aw_hs;
        got_w  <= got_w || w_hs;
      end
      if (bus.s_rvalid && bus.s_rready) bus.s_rvalid <= 1'b0;
      if (bus.s_arvalid && bus.s_arready) begin
        rd_addr <= bus.s_araddr;
        ar_pend <= 1'b1;
      end else if (ar_pend && !hold_r) begin
        bus.s_rvalid <= 1'b1;
        bus.s_rdata  <= rmodel(rd_addr);
        ar_pend      <= 1'b0;
      end
    end
  end

  task automatic pop_s(logic [1:0] k, logic [31:0] v);
    sev_t e;
    if (sq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sbus_event kind=%0d actual=%h required=none",
               k, v);
    end else begin
      e = sq.pop_front();
      chk("sbus_kind", 32'(k), 32'(e.kind));
      chk("sbus_val", v, e.val);
    end
  endtask

  task automatic pop_r(logic r, logic m, logic [31:0] d);
    rev_t e;
    if (rq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL resp_event master=%0d actual=%h required=none",
               m, d);
    end else begin
      e = rq.pop_front();
      chk("resp_kind", 32'(r), 32'(e.is_r));
      chk("resp_master", 32'(m), 32'(e.m));
      chk("resp_data", d, e.data);
      chk("resp_timeout", 32'(timeout), 32'(e.to));
      chk("resp_grant", 32'(grant), e.m ? 32'd2 : 32'd1);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.s_awvalid) awv_n++;
      if (bus.s_wvalid) wv_n++;
      if (bus.s_arvalid)
        chk("ar_excl", 32'({bus.s_awvalid, bus.s_wvalid,
                            bus.s_bready}), 32'd0);
      if (aw_hs) pop_s(2'd0, bus.s_awaddr);
      if (w_hs) pop_s(2'd1, bus.s_wdata);
      if (bus.s_arvalid && bus.s_arready)
        pop_s(2'd2, bus.s_araddr);
      for (int m = 0; m < 2; m++) begin
        if (bus.m_awready[m]) aw_cyc[m] = cyc;
        if (bus.m_arready[m]) begin
          ar_cyc[m] = cyc;
          ar_n[m]++;
        end
        if (bus.m_bvalid[m] && bus.m_bready[m]) begin
          b_cyc[m] = cyc;
          pop_r(1'b0, 1'(m), 32'd0);
        end
        if (bus.m_rvalid[m] && bus.m_rready[m]) begin
          r_cyc[m] = cyc;
          pop_r(1'b1, 1'(m), bus.m_rdata[m]);
        end
      end
    end
  end

  task automatic mwrite(logic m, logic [31:0] a, logic [31:0] d);
    bit ok;
    @(posedge clk);
    #1;
    bus.m_awaddr[m]  = a;
    bus.m_wdata[m]   = d;
    bus.m_awvalid[m] = 1'b1;
    bus.m_wvalid[m]  = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.m_awready[m] && bus.m_wready[m];
    end
    @(posedge clk);
    #1;
    bus.m_awvalid[m] = 1'b0;
    bus.m_wvalid[m]  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wr_grant_wait master=%0d actual=none required=grant",
               m);
    end
  endtask

  task automatic mread(logic m, logic [31:0] a);
    bit ok;
    @(posedge clk);
    #1;
    bus.m_araddr[m]  = a;
    bus.m_arvalid[m] = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.m_arready[m];
    end
    @(posedge clk);
    #1;
    bus.m_arvalid[m] = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rd_grant_wait master=%0d actual=none required=grant",
               m);
    end
  endtask

  task automatic drain(string n);
    bit ok;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = sq.size() == 0 && rq.size() == 0 && grant == 2'b00;
    end
    chk({n, "_drain"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int a0;
    int w0;
    int n1;
    bit ok;
    rst           = 1'b1;
    hold_b        = 1'b0;
    hold_r        = 1'b0;
    w_stall       = 1'b0;
    bus.m_awaddr  = '0;
    bus.m_awvalid = '0;
    bus.m_wdata   = '0;
    bus.m_wvalid  = '0;
    bus.m_araddr  = '0;
    bus.m_arvalid = '0;
    bus.m_bready  = 2'b11;
    bus.m_rready  = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_slave", 32'({bus.s_awvalid, bus.s_wvalid, bus.s_arvalid,
                          bus.s_bready, bus.s_rready}), 32'd0);
    chk("rst_master", 32'({bus.m_awready, bus.m_wready, bus.m_arready,
                           bus.m_bvalid, bus.m_rvalid}), 32'd0);
    chk("rst_rdata", 32'(bus.m_rdata), 32'd0);
    rst = 1'b0;

    // Simultaneous reads: M0 first after reset, then M1
    for (int k = 0; k < 2; k++) begin
      sq.push_back(sev(2'd2, 32'h2000_0000 + 32'(k * 32)));
      sq.push_back(sev(2'd2, 32'h2000_0010 + 32'(k * 32)));
      rq.push_back(rev(1'b1, 1'b0, 1'b0,
                       rmodel(32'h2000_0000 + 32'(k * 32))));
      rq.push_back(rev(1'b1, 1'b1, 1'b0,
                       rmodel(32'h2000_0010 + 32'(k * 32))));
      fork
        mread(1'b0, 32'h2000_0000 + 32'(k * 32));
        mread(1'b1, 32'h2000_0010 + 32'(k * 32));
      join
      drain("rr");
      chk("rr_gap", 32'(ar_cyc[1] - r_cyc[0]), 32'd1);
    end

    // Zero-wait single write from M0
    sq.push_back(sev(2'd0, 32'h1000_0004));
    sq.push_back(sev(2'd1, 32'h0000_00A5));
    rq.push_back(rev(1'b0, 1'b0, 1'b0, 32'd0));
    mwrite(1'b0, 32'h1000_0004, 32'h0000_00A5);
    drain("wr0");
    chk("wr0_latency", 32'(b_cyc[0] - aw_cyc[0]), 32'd2);

    // awvalid without wvalid is not a request
    @(posedge clk);
    #1;
    bus.m_awaddr[0]  = 32'h1111_0000;
    bus.m_awvalid[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("aw_only_grant", 32'(grant), 32'd0);
      chk("aw_only_ready", 32'(bus.m_awready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.m_awvalid[0] = 1'b0;

    // M1 write and read together: write first
    sq.push_back(sev(2'd0, 32'h3000_0000));
    sq.push_back(sev(2'd1, 32'h0000_5A5A));
    sq.push_back(sev(2'd2, 32'h3000_0100));
    rq.push_back(rev(1'b0, 1'b1, 1'b0, 32'd0));
    rq.push_back(rev(1'b1, 1'b1, 1'b0, rmodel(32'h3000_0100)));
    fork
      mwrite(1'b1, 32'h3000_0000, 32'h0000_5A5A);
      mread(1'b1, 32'h3000_0100);
    join
    drain("wr_then_rd");

    // Address accepted a cycle ahead of data
    w_stall = 1'b1;
    a0 = awv_n;
    w0 = wv_n;
    sq.push_back(sev(2'd0, 32'h3300_0008));
    sq.push_back(sev(2'd1, 32'hCAFE_0001));
    rq.push_back(rev(1'b0, 1'b0, 1'b0, 32'd0));
    mwrite(1'b0, 32'h3300_0008, 32'hCAFE_0001);
    drain("split");
    w_stall = 1'b0;
    chk("split_aw_cycles", 32'(awv_n - a0), 32'd1);
    chk("split_w_cycles", 32'(wv_n - w0), 32'd2);

    // M1 read request withdrawn while M0 busy: never granted
    hold_b = 1'b1;
    sq.push_back(sev(2'd0, 32'h4000_0000));
    sq.push_back(sev(2'd1, 32'h0000_0042));
    rq.push_back(rev(1'b0, 1'b0, 1'b0, 32'd0));
    mwrite(1'b0, 32'h4000_0000, 32'h0000_0042);
    n1 = ar_n[1];
    @(posedge clk);
    #1;
    bus.m_araddr[1]  = 32'h4400_0000;
    bus.m_arvalid[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.m_arvalid[1] = 1'b0;
    hold_b = 1'b0;
    drain("withdrawn");
    chk("withdrawn_ar", 32'(ar_n[1] - n1), 32'd0);

    // Reset while waiting for the write response
    hold_b = 1'b1;
    sq.push_back(sev(2'd0, 32'h5000_0000));
    sq.push_back(sev(2'd1, 32'h0000_0077));
    mwrite(1'b0, 32'h5000_0000, 32'h0000_0077);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.s_bready;
    end
    chk("wr_resp_reached", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_bready", 32'(bus.s_bready), 32'd0);
    rst    = 1'b0;
    hold_b = 1'b0;
    sq.push_back(sev(2'd0, 32'h5100_0000));
    sq.push_back(sev(2'd1, 32'h0000_0088));
    rq.push_back(rev(1'b0, 1'b1, 1'b0, 32'd0));
    mwrite(1'b1, 32'h5100_0000, 32'h0000_0088);
    drain("post_rst");

    // Slave never returns read data
    hold_r = 1'b1;
    sq.push_back(sev(2'd2, 32'h6000_0000));
`ifdef PERIPH_BUS_ARBITER_TIMEOUT_EN
    rq.push_back(rev(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF));
    mread(1'b0, 32'h6000_0000);
    drain("forced");
`else
    mread(1'b0, 32'h6000_0000);
    repeat (20) @(negedge clk);
    chk("stall_grant", 32'(grant), 32'd1);
    chk("stall_rvalid", 32'(bus.m_rvalid), 32'd0);
    chk("stall_timeout", 32'(timeout), 32'd0);
    rq.push_back(rev(1'b1, 1'b0, 1'b0, rmodel(32'h6000_0000)));
    hold_r = 1'b0;
    drain("stall_release");
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    hold_r = 1'b0;
    repeat (2) @(negedge clk);

    chk("sq_left", 32'(sq.size()), 32'd0);
    chk("rq_left", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
